// File: rtl/ms_event_timer.sv
// rtl/ms_event_timer.sv - prescaled tick generator driving a one-shot/periodic countdown
// Expiry pulses coincide with a tick, except a zero-length start, which expires on the next edge.
module ms_event_timer #(
  parameter int CLK_DIV = 50000,
  parameter int PRE_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             expire,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             expire_q, expire_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wrap;

  // start re-phases the prescaler so the first decrement is a full period away
  always_comb begin
    wrap   = enable && (pre_q == PRE_MAX);
    tick_d = wrap;
    pre_d  = pre_q;
    if (!enable || start || wrap) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    if (start) begin
      rem_d    = load_val;
      period_d = load_val;
      mode_d   = mode;
      if (load_val == '0) begin
        state_d  = IDLE;
        expire_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = IDLE;
      end else if (wrap) begin
        if (rem_q > CNT_W'(1)) begin
          rem_d = rem_q - 1'b1;
        end else if (mode_q) begin
          rem_d    = period_q;
          expire_d = 1'b1;
        end else begin
          rem_d    = '0;
          expire_d = 1'b1;
          state_d  = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      expire_q <= 1'b0;
      mode_q   <= 1'b0;
      rem_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      expire_q <= expire_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      period_q <= period_d;
    end
  end

  assign tick      = tick_q;
  assign expire    = expire_q;
  assign busy      = (state_q == RUN);
  assign remaining = rem_q;

endmodule

// File: tb/tb_ms_event_timer.sv
// tb/tb_ms_event_timer.sv - scoreboard bench for ms_event_timer with CLK_DIV=4, CNT_W=8
module tb_ms_event_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] load_val;
  logic       tick;
  logic       expire;
  logic       busy;
  logic [7:0] remaining;

  always #5 clk = ~clk;

  ms_event_timer #(
    .CLK_DIV(4),
    .PRE_W  (3),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load_val (load_val),
    .tick     (tick),
    .expire   (expire),
    .busy     (busy),
    .remaining(remaining)
  );

  typedef struct {
    logic       t;
    logic       e;
    logic       b;
    logic [7:0] r;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   n_pass   = 0;
  int   n_checks = 0;

  // push the outputs expected after the coming edge, then advance one cycle
  task automatic step(input int t, input int e, input int b, input int r, input string name);
    exp_t x;
    x.t    = (t != 0);
    x.e    = (e != 0);
    x.b    = (b != 0);
    x.r    = 8'(r);
    x.name = name;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      n_checks++;
      if ({tick, expire, busy, remaining} === {mon_x.t, mon_x.e, mon_x.b, mon_x.r}) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got tick=%0b expire=%0b busy=%0b remaining=%0d, required tick=%0b expire=%0b busy=%0b remaining=%0d",
                 mon_x.name, tick, expire, busy, remaining, mon_x.t, mon_x.e, mon_x.b, mon_x.r);
      end
    end
  end

  initial begin
    rst      = 1'b0;
    enable   = 1'b1;
    start    = 1'b1;
    stop     = 1'b0;
    mode     = 1'b1;
    load_val = 8'd7;

    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, $sformatf("reset_%0d", i));

    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    load_val = 8'd0;
    for (int i = 1; i <= 20; i++) step(i % 4 == 0, 0, 0, 0, $sformatf("presc_%0d", i));

    for (int i = 1; i <= 20; i++) begin
      enable = !(i >= 6 && i <= 8);
      step(i == 4 || i == 12 || i == 16 || i == 20, 0, 0, 0, $sformatf("presc_gap_%0d", i));
    end
    enable = 1'b1;

    load_val = 8'd3;
    mode     = 1'b0;
    start    = 1'b1;
    step(0, 0, 1, 3, "oneshot_start");
    start    = 1'b0;
    load_val = 8'd9;
    mode     = 1'b1;
    for (int k = 1; k <= 16; k++)
      step(k % 4 == 0, k == 12, k < 12, (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0,
           $sformatf("oneshot_%0d", k));

    load_val = 8'd2;
    mode     = 1'b1;
    start    = 1'b1;
    step(0, 0, 1, 2, "periodic_start");
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      stop = (k == 21);
      if (k <= 20)
        step(k % 4 == 0, k % 8 == 0, 1, ((k / 4) % 2 == 0) ? 2 : 1, $sformatf("periodic_%0d", k));
      else
        step(k % 4 == 0, 0, 0, 1, $sformatf("stopped_%0d", k));
    end
    stop = 1'b0;

    load_val = 8'd0;
    mode     = 1'b1;
    start    = 1'b1;
    step(0, 1, 0, 0, "zero_start");
    start = 1'b0;
    for (int k = 1; k <= 8; k++) step(k % 4 == 0, 0, 0, 0, $sformatf("zero_after_%0d", k));

    load_val = 8'd2;
    mode     = 1'b0;
    start    = 1'b1;
    stop     = 1'b1;
    step(0, 0, 1, 2, "start_stop");
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 1; k <= 6; k++) step(k % 4 == 0, 0, 1, (k < 4) ? 2 : 1, $sformatf("ss_run_%0d", k));

    load_val = 8'd5;
    start    = 1'b1;
    step(0, 0, 1, 5, "restart");
    start = 1'b0;
    for (int k = 1; k <= 20; k++)
      step(k % 4 == 0, k == 20, k < 20, 5 - k / 4, $sformatf("restart_%0d", k));

    load_val = 8'd2;
    mode     = 1'b1;
    start    = 1'b1;
    step(0, 0, 1, 2, "pre_reset_start");
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step(k == 4, 0, 1, (k < 4) ? 2 : 1, $sformatf("pre_reset_%0d", k));
    rst = 1'b0;
    step(0, 0, 0, 0, "mid_reset");
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) step(k % 4 == 0, 0, 0, 0, $sformatf("post_reset_%0d", k));

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
